// File: rtl/memory_arbiter.sv
// ============================================================================
// Module   : memory_arbiter
// Brief    : Grants the single-ported RAM to either the icache or the dcache.
//            The dcache wins by default. Defining ARB_STARVE_GUARD_EN adds a
//            starvation guard that bounds how long a waiting icache is held off.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module memory_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam logic [1:0] c_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_dreq;
  logic   w_access;
  logic   w_force_i;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == c_ACCESS);
  assign iload    = ramload;
  assign dload    = ramload;

`ifdef ARB_STARVE_GUARD_EN
  localparam int            c_CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

  logic [c_CNT_W-1:0] r_starve;

  // Counts dcache wins against a waiting icache; an icache grant clears it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve <= '0;
    end else if (r_state == IDLE) begin
      if (w_next == IGNT) begin
        r_starve <= '0;
      end else if (w_next == DGNT && iREN && r_starve != c_LIMIT) begin
        r_starve <= r_starve + 1'b1;
      end
    end
  end

  assign w_force_i = iREN && (r_starve == c_LIMIT);
`else
  assign w_force_i = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (r_state)
      IDLE: begin
        if (w_force_i) begin
          w_next = IGNT;
        end else if (w_dreq) begin
          w_next = DGNT;
        end else if (iREN) begin
          w_next = IGNT;
        end
      end
      DGNT: begin
        // Enables follow the live request so a withdrawn access stops at once.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = ~(w_dreq & w_access);
        if (!w_dreq || w_access) begin
          w_next = IDLE;
        end
      end
      IGNT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = ~(iREN & w_access);
        if (!iREN || w_access) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_arbiter.sv
// ============================================================================
// Module   : tb_memory_arbiter
// Brief    : Directed self-checking bench for memory_arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_memory_arbiter;

`ifdef ARB_STARVE_GUARD_EN
  localparam int c_LIMIT       = 2;
  localparam int c_STARVE_EXP  = 2;
`else
  localparam int c_LIMIT       = 4;
  localparam int c_STARVE_EXP  = 3;
`endif

  localparam logic [1:0] c_FREE   = 2'd0;
  localparam logic [1:0] c_BUSY   = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  memory_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(c_LIMIT)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  task automatic test_reset();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h10; daddr = 32'h20;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_tests++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL reset_ramREN got=%b exp=0", ramREN); end
    n_tests++; if (ramWEN !== 1'b0) begin n_fail++; $display("FAIL reset_ramWEN got=%b exp=0", ramWEN); end
    n_tests++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL reset_iwait got=%b exp=1", iwait); end
    n_tests++; if (dwait !== 1'b1) begin n_fail++; $display("FAIL reset_dwait got=%b exp=1", dwait); end
    n_tests++; if (ramaddr !== 32'h0) begin n_fail++; $display("FAIL reset_ramaddr got=%h exp=0", ramaddr); end
    iREN = 1'b0; dREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    iaddr = 32'h40; iREN = 1'b1; ramstate = c_FREE; ramload = 32'h1234_5678;
    #1;
    n_tests++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL fetch_arb_ramREN got=%b exp=0", ramREN); end
    step(); ramstate = c_BUSY; #1;
    n_tests++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL fetch_grant_ramREN got=%b exp=1", ramREN); end
    n_tests++; if (ramaddr !== 32'h40) begin n_fail++; $display("FAIL fetch_grant_ramaddr got=%h exp=40", ramaddr); end
    n_tests++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL fetch_busy_iwait got=%b exp=1", iwait); end
    step(); #1;
    n_tests++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL fetch_busy2_iwait got=%b exp=1", iwait); end
    step(); ramstate = c_ACCESS; #1;
    n_tests++; if (iwait !== 1'b0) begin n_fail++; $display("FAIL fetch_access_iwait got=%b exp=0", iwait); end
    n_tests++; if (iload !== 32'h1234_5678) begin n_fail++; $display("FAIL fetch_iload got=%h exp=12345678", iload); end
    step(); iREN = 1'b0; ramstate = c_FREE; #1;
    n_tests++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL fetch_idle got ramREN=%b iwait=%b exp 0/1", ramREN, iwait); end
  endtask

  task automatic test_contention();
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF; ramstate = c_FREE;
    #1;
    n_tests++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin n_fail++; $display("FAIL cont_arb got ramWEN=%b ramREN=%b exp 0/0", ramWEN, ramREN); end
    step(); ramstate = c_BUSY; #1;
    n_tests++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin n_fail++; $display("FAIL cont_write_en got ramWEN=%b ramREN=%b exp 1/0", ramWEN, ramREN); end
    n_tests++; if (ramstore !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cont_ramstore got=%h exp=deadbeef", ramstore); end
    n_tests++; if (ramaddr !== 32'h80) begin n_fail++; $display("FAIL cont_ramaddr got=%h exp=80", ramaddr); end
    n_tests++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL cont_busy_iwait got=%b exp=1", iwait); end
    step(); ramstate = c_ACCESS; #1;
    n_tests++; if (dwait !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL cont_access got dwait=%b iwait=%b exp 0/1", dwait, iwait); end
    step(); dWEN = 1'b0; ramstate = c_FREE; #1;
    n_tests++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL cont_gap got ramREN=%b iwait=%b exp 0/1", ramREN, iwait); end
    step(); ramstate = c_ACCESS; #1;
    n_tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin n_fail++; $display("FAIL cont_fetch got ramREN=%b ramaddr=%h exp 1/44", ramREN, ramaddr); end
    n_tests++; if (iwait !== 1'b0) begin n_fail++; $display("FAIL cont_fetch_iwait got=%b exp=0", iwait); end
    step(); iREN = 1'b0; ramstate = c_FREE; #1;
  endtask

  task automatic test_both_en();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'hC0; dstore = 32'h0000_00A5;
    step(); ramstate = c_BUSY; #1;
    n_tests++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin n_fail++; $display("FAIL both_en got ramWEN=%b ramREN=%b exp 1/0", ramWEN, ramREN); end
    step(); ramstate = c_ACCESS; #1;
    n_tests++; if (dwait !== 1'b0) begin n_fail++; $display("FAIL both_access_dwait got=%b exp=0", dwait); end
    step(); dREN = 1'b0; dWEN = 1'b0; ramstate = c_FREE; #1;
  endtask

  task automatic test_abort();
    dREN = 1'b1; daddr = 32'h100;
    step(); ramstate = c_BUSY; #1;
    n_tests++; if (ramREN !== 1'b1 || dwait !== 1'b1) begin n_fail++; $display("FAIL abort_grant got ramREN=%b dwait=%b exp 1/1", ramREN, dwait); end
    step(); dREN = 1'b0; #1;
    n_tests++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin n_fail++; $display("FAIL abort_drop got ramREN=%b dwait=%b exp 0/1", ramREN, dwait); end
    step(); iREN = 1'b1; iaddr = 32'h50; ramstate = c_FREE; #1;
    n_tests++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL abort_idle_ramREN got=%b exp=0", ramREN); end
    step(); #1;
    n_tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h50) begin n_fail++; $display("FAIL abort_next_grant got ramREN=%b ramaddr=%h exp 1/50", ramREN, ramaddr); end
    iREN = 1'b0;
    step(); #1;
  endtask

  task automatic test_error_hold();
    iREN = 1'b1; iaddr = 32'h48;
    step(); ramstate = c_ERROR; #1;
    n_tests++; if (iwait !== 1'b1 || ramREN !== 1'b1) begin n_fail++; $display("FAIL err_hold got iwait=%b ramREN=%b exp 1/1", iwait, ramREN); end
    dREN = 1'b1; daddr = 32'h300;
    step(); #1;
    n_tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h48 || dwait !== 1'b1) begin n_fail++; $display("FAIL err_no_preempt got ramREN=%b ramaddr=%h dwait=%b exp 1/48/1", ramREN, ramaddr, dwait); end
    step(); ramstate = c_ACCESS; #1;
    n_tests++; if (iwait !== 1'b0 || dwait !== 1'b1) begin n_fail++; $display("FAIL err_complete got iwait=%b dwait=%b exp 0/1", iwait, dwait); end
    step(); iREN = 1'b0; ramstate = c_FREE; #1;
    n_tests++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL err_gap_ramREN got=%b exp=0", ramREN); end
    step(); #1;
    n_tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h300) begin n_fail++; $display("FAIL err_dgrant got ramREN=%b ramaddr=%h exp 1/300", ramREN, ramaddr); end
    dREN = 1'b0;
    step(); #1;
  endtask

  task automatic test_async_reset();
    dWEN = 1'b1; daddr = 32'h400; dstore = 32'h5555_AAAA;
    step(); ramstate = c_BUSY; #1;
    n_tests++; if (ramWEN !== 1'b1) begin n_fail++; $display("FAIL areset_pre got=%b exp=1", ramWEN); end
    #1 nRST = 1'b0;
    #1;
    n_tests++; if (ramWEN !== 1'b0 || ramaddr !== 32'h0 || dwait !== 1'b1) begin n_fail++; $display("FAIL areset_drop got ramWEN=%b ramaddr=%h dwait=%b exp 0/0/1", ramWEN, ramaddr, dwait); end
    dWEN = 1'b0; ramstate = c_FREE;
    @(negedge CLK);
    nRST = 1'b1;
    step();
  endtask

  task automatic test_starve();
    int dcnt;
    int got;
    do_reset();
    iREN = 1'b1; iaddr = 32'h4C; dREN = 1'b1; daddr = 32'h200; ramstate = c_ACCESS;
    dcnt = 0;
    got  = -1;
    for (int c = 0; c < 20 && got < 0; c++) begin
      #1;
      if (!dwait) dcnt++;
      if (!iwait) got = dcnt;
      if (dcnt >= 3) dREN = 1'b0;
      step();
    end
    iREN = 1'b0; dREN = 1'b0; ramstate = c_FREE;
    n_tests++; if (got !== c_STARVE_EXP) begin n_fail++; $display("FAIL starve_grant dcache_accesses_before_fetch got=%0d exp=%0d", got, c_STARVE_EXP); end
    step();
  endtask

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = c_FREE;
    test_reset();
    test_fetch();
    test_contention();
    test_both_en();
    test_abort();
    test_error_hold();
    test_async_reset();
    test_starve();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
